// File: rtl/ddr2_fifo_sched_pkg.sv
// Shared definitions for the DDR2 FIFO burst scheduler: command codes, FSM states,
// and the BL4 burst-to-column address mapping.
package ddr2_fifo_sched_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    // One BL4 burst spans 4 columns, so a burst index maps to a column by a shift of 2.
    localparam int COL_STEP_LOG2 = 2;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_ARB  = 3'd1,
        ST_WR0  = 3'd2,
        ST_WR1  = 3'd3,
        ST_RD   = 3'd4
    } sched_state_t;

    function automatic logic [30:0] burst_addr(input logic [30:0] base, input logic [30:0] idx);
        return base + (idx << COL_STEP_LOG2);
    endfunction

endpackage

// File: rtl/ddr2_fifo_sched_if.sv
// Bus bundle between the burst scheduler (master) and its staging FIFOs / MIG app port (slave).
interface ddr2_fifo_sched_if #(
    parameter int APP_W = 128,
    parameter int CNT_W = 9
);
    // Handshakes: a strobe (in_rd_en, out_wr_en, app_af_wren, app_wdf_wren, rd_data_valid)
    // transfers its data in the cycle it is high; the only back-pressure is in_cnt, out_free
    // and the *_afull flags, which the scheduler checks before it starts a burst.
    logic [APP_W-1:0]   in_data;
    logic [CNT_W-1:0]   in_cnt;
    logic               in_rd_en;
    logic [CNT_W-1:0]   out_free;
    logic [APP_W-1:0]   out_data;
    logic               out_wr_en;
    logic [2:0]         app_af_cmd;
    logic [30:0]        app_af_addr;
    logic               app_af_wren;
    logic               app_af_afull;
    logic [APP_W-1:0]   app_wdf_data;
    logic [APP_W/8-1:0] app_wdf_mask_data;
    logic               app_wdf_wren;
    logic               app_wdf_afull;
    logic               rd_data_valid;
    logic [APP_W-1:0]   rd_data_fifo_out;

    modport master (
        input  in_data, in_cnt, out_free, app_af_afull, app_wdf_afull,
               rd_data_valid, rd_data_fifo_out,
        output in_rd_en, out_data, out_wr_en, app_af_cmd, app_af_addr, app_af_wren,
               app_wdf_data, app_wdf_mask_data, app_wdf_wren
    );

    modport slave (
        output in_data, in_cnt, out_free, app_af_afull, app_wdf_afull,
               rd_data_valid, rd_data_fifo_out,
        input  in_rd_en, out_data, out_wr_en, app_af_cmd, app_af_addr, app_af_wren,
               app_wdf_data, app_wdf_mask_data, app_wdf_wren
    );
endinterface

// File: rtl/ddr2_fifo_sched_rd_tracker.sv
// Read-return bookkeeping: outstanding bursts, beat position, stray-word detection and
// the read-staging space reservation check.
module ddr2_fifo_sched_rd_tracker #(
    parameter int APP_W       = 128,
    parameter int CNT_W       = 9,
    parameter int BURST_WORDS = 2,
    parameter int MAX_RD_OUT  = 4,
    parameter int OUT_W       = $clog2(MAX_RD_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic             rd_data_valid,
    input  logic [APP_W-1:0] rd_data,
    input  logic [CNT_W-1:0] out_free,
    output logic [APP_W-1:0] out_data,
    output logic             out_wr_en,
    output logic             err_stray,
    output logic             rd_room,
    output logic [OUT_W-1:0] outstanding
);
    localparam int BEAT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

    logic [BEAT_W-1:0] beat;
    logic              accept;
    logic              last_beat;
    logic [31:0]       need;

    assign accept    = rd_data_valid && (outstanding != '0);
    assign last_beat = accept && (beat == BEAT_W'(BURST_WORDS - 1));
    assign out_wr_en = accept;
    assign out_data  = rd_data;

    // Every burst already in flight plus the one about to issue must fit in the read FIFO.
    assign need    = (32'(outstanding) + 32'd1) * 32'(BURST_WORDS);
    assign rd_room = (outstanding < OUT_W'(MAX_RD_OUT)) && (32'(out_free) >= need);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
            beat        <= '0;
            err_stray   <= 1'b0;
        end else begin
            err_stray <= rd_data_valid && (outstanding == '0);
            if (accept) begin
                beat <= last_beat ? '0 : beat + BEAT_W'(1);
            end
            case ({issue, last_beat})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: rtl/ddr2_fifo_sched.sv
// Burst scheduler: drains the write-staging FIFO into a DDR2 ring buffer and refills the
// read-staging FIFO from it, arbitrating both onto one MIG app interface.
module ddr2_fifo_sched
    import ddr2_fifo_sched_pkg::*;
#(
    parameter int          APP_W       = 128,
    parameter logic [30:0] BASE_ADDR   = 31'h0,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          BURST_WORDS = 2,
    parameter int          MAX_RD_OUT  = 4,
    parameter int          CNT_W       = 9
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              phy_init_done,
    ddr2_fifo_sched_if.master bus,
    output logic              full,
    output logic              empty,
    output logic              err_stray,
    output sched_state_t      dbg_state
);
    localparam int OUT_W = $clog2(MAX_RD_OUT + 1);

    sched_state_t      state;
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [DEPTH_LOG2:0] stored;
    logic              last_wr;
    logic              af_wren;
    logic [2:0]        af_cmd;
    logic [30:0]       af_addr;
    logic              wdf_wren;
    logic              rd_en;
    logic              wr_ok;
    logic              rd_ok;
    logic              rd_room;
    logic              grant_wr;
    logic              grant_rd;
    logic [OUT_W-1:0]  outstanding;
    logic [30:0]       wr_addr;
    logic [30:0]       rd_addr;

    assign stored = wr_ptr - rd_ptr;
    assign full   = (stored == {1'b1, {DEPTH_LOG2{1'b0}}});
    assign empty  = (stored == '0) && (outstanding == '0);

    assign wr_addr = burst_addr(BASE_ADDR, 31'(wr_ptr[DEPTH_LOG2-1:0]));
    assign rd_addr = burst_addr(BASE_ADDR, 31'(rd_ptr[DEPTH_LOG2-1:0]));

    assign wr_ok = phy_init_done && (bus.in_cnt >= CNT_W'(BURST_WORDS)) && !full
                   && !bus.app_af_afull && !bus.app_wdf_afull;
    assign rd_ok = phy_init_done && (stored != '0) && rd_room && !bus.app_af_afull;

    // Round-robin under contention: the side granted last time yields.
    assign grant_wr = wr_ok && (!rd_ok || !last_wr);
    assign grant_rd = rd_ok && !grant_wr;

    // FWFT head goes straight to the write-data FIFO; the pop in each WR beat exposes the next word.
    assign bus.app_wdf_data      = bus.in_data;
    assign bus.app_wdf_mask_data = '0;
    assign bus.app_wdf_wren      = wdf_wren;
    assign bus.app_af_wren       = af_wren;
    assign bus.app_af_cmd        = af_cmd;
    assign bus.app_af_addr       = af_addr;
    assign bus.in_rd_en          = rd_en;
    assign dbg_state             = state;

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_wr  <= 1'b0;
            af_wren  <= 1'b0;
            af_cmd   <= CMD_WR;
            af_addr  <= '0;
            wdf_wren <= 1'b0;
            rd_en    <= 1'b0;
        end else begin
            af_wren  <= 1'b0;
            wdf_wren <= 1'b0;
            rd_en    <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (phy_init_done) state <= ST_ARB;
                end
                ST_ARB: begin
                    if (grant_wr) begin
                        state    <= ST_WR0;
                        af_wren  <= 1'b1;
                        af_cmd   <= CMD_WR;
                        af_addr  <= wr_addr;
                        wdf_wren <= 1'b1;
                        rd_en    <= 1'b1;
                        last_wr  <= 1'b1;
                    end else if (grant_rd) begin
                        state   <= ST_RD;
                        af_wren <= 1'b1;
                        af_cmd  <= CMD_RD;
                        af_addr <= rd_addr;
                        last_wr <= 1'b0;
                    end
                end
                ST_WR0: begin
                    state    <= ST_WR1;
                    wdf_wren <= 1'b1;
                    rd_en    <= 1'b1;
                end
                ST_WR1: begin
                    state  <= ST_ARB;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                ST_RD: begin
                    state  <= ST_ARB;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    ddr2_fifo_sched_rd_tracker #(
        .APP_W      (APP_W),
        .CNT_W      (CNT_W),
        .BURST_WORDS(BURST_WORDS),
        .MAX_RD_OUT (MAX_RD_OUT),
        .OUT_W      (OUT_W)
    ) u_rd_tracker (
        .clk          (sys_clk),
        .rst_n        (reset_n),
        .issue        (state == ST_RD),
        .rd_data_valid(bus.rd_data_valid),
        .rd_data      (bus.rd_data_fifo_out),
        .out_free     (bus.out_free),
        .out_data     (bus.out_data),
        .out_wr_en    (bus.out_wr_en),
        .err_stray    (err_stray),
        .rd_room      (rd_room),
        .outstanding  (outstanding)
    );

endmodule

// File: tb/tb_ddr2_fifo_sched.sv
// Directed bench for ddr2_fifo_sched with a 4-burst ring, a staging-FIFO model and a
// fixed-latency DDR2 model returning read data 20 cycles after each read command.
module tb_ddr2_fifo_sched;
    import ddr2_fifo_sched_pkg::*;

    localparam int W = 128;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         phy_init_done;
    logic         full;
    logic         empty;
    logic         err_stray;
    sched_state_t dbg_state;

    ddr2_fifo_sched_if #(.APP_W(W), .CNT_W(9)) bus ();

    ddr2_fifo_sched #(
        .APP_W(W), .BASE_ADDR(31'h0), .DEPTH_LOG2(2),
        .BURST_WORDS(2), .MAX_RD_OUT(4), .CNT_W(9)
    ) dut (
        .sys_clk      (clk),
        .reset_n      (reset_n),
        .phy_init_done(phy_init_done),
        .bus          (bus.master),
        .full         (full),
        .empty        (empty),
        .err_stray    (err_stray),
        .dbg_state    (dbg_state)
    );

    // ---------------- environment state ----------------
    typedef struct {
        int           due;
        logic [W-1:0] data;
    } ret_t;

    logic [W-1:0] in_fifo[$];
    logic [W-1:0] out_q[$];
    logic [W-1:0] exp_q[$];
    logic [33:0]  cmd_log[$];
    ret_t         ret_q[$];
    logic [W-1:0] mem[0:3][0:1];

    int cyc, rd_en_cnt, stray_cnt, model_out, max_out, ret_beats, wbeat;
    logic [1:0] wr_slot;
    logic pop_req, stray_pending;
    int n_vec, n_miss;

    task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_word(input int t, input int i);
        return {32'(t), 64'h0123_4567_89ab_cdef, 32'(i)};
    endfunction

    // ---------------- driver: one clock of staging-FIFO and DDR2 model ----------------
    task automatic tick();
        logic [1:0] slot;
        @(posedge clk);
        #1;
        if (pop_req && in_fifo.size() != 0) void'(in_fifo.pop_front());
        if (stray_pending) begin
            bus.rd_data_valid    = 1'b1;
            bus.rd_data_fifo_out = 128'hdead_beef;
            stray_pending        = 1'b0;
        end else if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
            bus.rd_data_valid    = 1'b1;
            bus.rd_data_fifo_out = ret_q[0].data;
            void'(ret_q.pop_front());
        end else begin
            bus.rd_data_valid    = 1'b0;
            bus.rd_data_fifo_out = '0;
        end
        bus.in_cnt  = 9'(in_fifo.size());
        bus.in_data = (in_fifo.size() != 0) ? in_fifo[0] : '0;
        cyc++;
        @(negedge clk);
        pop_req = bus.in_rd_en;
        if (bus.in_rd_en) rd_en_cnt++;
        if (bus.app_af_wren) begin
            cmd_log.push_back({bus.app_af_cmd, bus.app_af_addr});
            slot = bus.app_af_addr[3:2];
            if (bus.app_af_cmd == CMD_RD) begin
                ret_q.push_back('{cyc + 20, mem[slot][0]});
                ret_q.push_back('{cyc + 20, mem[slot][1]});
                model_out++;
                if (model_out > max_out) max_out = model_out;
            end else begin
                wr_slot = slot;
                wbeat   = 0;
            end
        end
        if (bus.app_wdf_wren) begin
            mem[wr_slot][wbeat[0]] = bus.app_wdf_data;
            wbeat++;
        end
        if (bus.out_wr_en) begin
            out_q.push_back(bus.out_data);
            ret_beats++;
            if (ret_beats == 2) begin
                ret_beats = 0;
                model_out--;
            end
        end
        if (err_stray) stray_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_fifo.delete(); out_q.delete(); exp_q.delete(); cmd_log.delete(); ret_q.delete();
        rd_en_cnt = 0; stray_cnt = 0; model_out = 0; max_out = 0; ret_beats = 0;
        pop_req = 1'b0;
        run(3);
        reset_n = 1'b1;
    endtask

    task automatic load_words(input int t, input int n, input bit expect_out);
        for (int i = 0; i < n; i++) begin
            in_fifo.push_back(mk_word(t, i));
            if (expect_out) exp_q.push_back(mk_word(t, i));
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_drain(input string tag);
        logic [W-1:0] got, exp;
        while (out_q.size() != 0 && exp_q.size() != 0) begin
            got = out_q.pop_front();
            exp = exp_q.pop_front();
            check_vec(tag, got, exp);
        end
        check_vec({tag, "_left"}, 128'(exp_q.size()), 128'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        n_vec = 0; n_miss = 0; cyc = 0; wbeat = 0; wr_slot = '0;
        stray_pending = 1'b0;
        phy_init_done = 1'b0;
        bus.out_free = '0; bus.app_af_afull = 1'b0; bus.app_wdf_afull = 1'b0;
        bus.rd_data_valid = 1'b0; bus.rd_data_fifo_out = '0;
        bus.in_data = '0; bus.in_cnt = '0;

        // reset values, calibration not done
        do_reset();
        check_vec("rst_af_wren", 128'(bus.app_af_wren), 128'd0);
        check_vec("rst_in_rd_en", 128'(bus.in_rd_en), 128'd0);
        check_vec("rst_out_wr_en", 128'(bus.out_wr_en), 128'd0);
        check_vec("rst_err_stray", 128'(err_stray), 128'd0);
        check_vec("rst_full", 128'(full), 128'd0);
        check_vec("rst_empty", 128'(empty), 128'd1);
        load_words(1, 8, 1'b0);
        run(10);
        check_vec("t1_no_cmd", 128'(cmd_log.size()), 128'd0);
        check_vec("t1_state_init", 128'(dbg_state), 128'(ST_INIT));
        check_vec("t1_empty", 128'(empty), 128'd1);
        check_vec("t1_no_pop", 128'(rd_en_cnt), 128'd0);

        // single write burst
        do_reset();
        load_words(2, 2, 1'b1);
        phy_init_done = 1'b1;
        run(10);
        check_vec("t2_ncmd", 128'(cmd_log.size()), 128'd1);
        check_vec("t2_wr_cmd", 128'(cmd_log[0]), 128'({CMD_WR, 31'h0}));
        check_vec("t2_pops", 128'(rd_en_cnt), 128'd2);
        check_vec("t2_empty", 128'(empty), 128'd0);
        check_vec("t2_full", 128'(full), 128'd0);
        check_vec("t2_mem0", mem[0][0], mk_word(2, 0));
        check_vec("t2_mem1", mem[0][1], mk_word(2, 1));
        check_vec("t2_state_arb", 128'(dbg_state), 128'(ST_ARB));

        // read it back
        bus.out_free = 9'd16;
        run(40);
        check_vec("t3_ncmd", 128'(cmd_log.size()), 128'd2);
        check_vec("t3_rd_cmd", 128'(cmd_log[1]), 128'({CMD_RD, 31'h0}));
        check_vec("t3_nout", 128'(out_q.size()), 128'd2);
        check_drain("t3_data");
        check_vec("t3_empty", 128'(empty), 128'd1);

        // fill the 4-burst ring, then wrap
        bus.out_free = '0;
        do_reset();
        load_words(4, 20, 1'b0);
        run(30);
        check_vec("t4_ncmd", 128'(cmd_log.size()), 128'd4);
        for (int i = 0; i < 4; i++)
            check_vec($sformatf("t4_wr%0d", i), 128'(cmd_log[i]), 128'({CMD_WR, 31'(4 * i)}));
        check_vec("t4_full", 128'(full), 128'd1);
        check_vec("t4_left_in", 128'(in_fifo.size()), 128'd12);
        bus.out_free = 9'd2;
        exp_q.push_back(mk_word(4, 0));
        exp_q.push_back(mk_word(4, 1));
        run(40);
        check_vec("t4_rd0", 128'(cmd_log[4]), 128'({CMD_RD, 31'h0}));
        check_vec("t4_wrap_wr", 128'(cmd_log[5]), 128'({CMD_WR, 31'h0}));
        for (int i = 0; i < 2; i++) begin
            if (out_q.size() != 0) check_vec($sformatf("t4_ret%0d", i), out_q.pop_front(), exp_q.pop_front());
            else check_vec("t4_ret_missing", 128'd0, 128'd1);
        end
        exp_q.delete();

        // continuous contention: alternation, read cap, full drain
        bus.out_free = 9'd64;
        do_reset();
        load_words(5, 40, 1'b1);
        for (int i = 0; i < 800 && out_q.size() < 40; i++) tick();
        check_vec("t5_nout", 128'(out_q.size()), 128'd40);
        check_vec("t5_g0", 128'(cmd_log[0]), 128'({CMD_WR, 31'h0}));
        check_vec("t5_g1", 128'(cmd_log[1]), 128'({CMD_RD, 31'h0}));
        check_vec("t5_g2", 128'(cmd_log[2]), 128'({CMD_WR, 31'h4}));
        check_vec("t5_g3", 128'(cmd_log[3]), 128'({CMD_RD, 31'h4}));
        check_vec("t5_g4", 128'(cmd_log[4]), 128'({CMD_WR, 31'h8}));
        check_vec("t5_g5", 128'(cmd_log[5]), 128'({CMD_RD, 31'h8}));
        check_vec("t5_max_out", 128'(max_out), 128'd4);
        check_drain("t5_data");
        run(3);
        check_vec("t5_empty", 128'(empty), 128'd1);

        // address FIFO almost full stalls both sides
        bus.app_af_afull = 1'b1;
        n0 = cmd_log.size();
        load_words(6, 4, 1'b1);
        run(20);
        check_vec("t5_afull_stall", 128'(cmd_log.size()), 128'(n0));
        bus.app_af_afull = 1'b0;
        run(60);
        check_vec("t5_afull_resume", 128'(cmd_log.size()), 128'(n0 + 4));
        check_drain("t5_afull_data");

        // stray return word right after reset
        phy_init_done = 1'b0;
        do_reset();
        stray_pending = 1'b1;
        run(5);
        check_vec("t6_stray_pulse", 128'(stray_cnt), 128'd1);
        check_vec("t6_no_push", 128'(out_q.size()), 128'd0);
        check_vec("t6_empty", 128'(empty), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
